// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with 3-sample majority voting,
// a valid/ready holding register, and frame-error / overrun pulses.
module uart_rx_os #(
   parameter int DIV        = 4,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_rxd,
   input  logic                 i_ready,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_frame_err,
   output logic                 o_overrun,
   output logic                 o_busy
);

   localparam int TW = $clog2(DIV);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int M  = OVERSAMPLE / 2;

   localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
   localparam logic [SW-1:0] S_PRE  = SW'(M - 1);
   localparam logic [SW-1:0] S_MID  = SW'(M);
   localparam logic [SW-1:0] S_DEC  = SW'(M + 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t               state;
   logic                 rx_meta;
   logic                 rxs;
   logic [TW-1:0]        tcnt;
   logic [SW-1:0]        scnt;
   logic [BW-1:0]        bidx;
   logic [DATA_BITS-1:0] shreg;
   logic                 v0;
   logic                 v1;

   logic tick;
   logic at_dec;
   logic vote;
   logic deliver;

   assign tick    = (state != IDLE) && (tcnt == T_LAST);
   assign at_dec  = tick && (scnt == S_DEC);
   assign vote    = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
   assign deliver = at_dec && (state == STOP) && vote;

   // Two-flop synchronizer; the line idles high so reset to 1.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= i_rxd;
         rxs     <= rx_meta;
      end
   end

   // Frame FSM: tick/sample counters, vote capture, shifting, flags.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state       <= IDLE;
         tcnt        <= '0;
         scnt        <= '0;
         bidx        <= '0;
         shreg       <= '0;
         v0          <= 1'b0;
         v1          <= 1'b0;
         o_frame_err <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         o_frame_err <= 1'b0;

         if (state == IDLE || tick) begin
            tcnt <= '0;
         end else begin
            tcnt <= tcnt + 1'b1;
         end

         if (tick && scnt == S_PRE) begin
            v0 <= rxs;
         end
         if (tick && scnt == S_MID) begin
            v1 <= rxs;
         end
         if (tick) begin
            scnt <= (scnt == S_LAST) ? '0 : scnt + 1'b1;
         end

         unique case (state)
            IDLE: begin
               if (!rxs) begin
                  state  <= START;
                  scnt   <= '0;
                  bidx   <= '0;
                  o_busy <= 1'b1;
               end
            end
            START: begin
               if (at_dec && vote) begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end else if (tick && scnt == S_LAST) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (at_dec) begin
                  shreg <= {vote, shreg[DATA_BITS-1:1]};
               end
               if (tick && scnt == S_LAST) begin
                  if (bidx == B_LAST) begin
                     state <= STOP;
                  end else begin
                     bidx <= bidx + 1'b1;
                  end
               end
            end
            STOP: begin
               if (at_dec) begin
                  if (vote) begin
                     state  <= IDLE;
                     o_busy <= 1'b0;
                  end else begin
                     state       <= BREAK;
                     o_frame_err <= 1'b1;
                  end
               end
            end
            BREAK: begin
               if (rxs) begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

   // Holding register: load on delivery if free or draining, else drop.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_data    <= '0;
         o_valid   <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         o_overrun <= deliver && o_valid && !i_ready;
         if (deliver && (!o_valid || i_ready)) begin
            o_data  <= shreg;
            o_valid <= 1'b1;
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Oversampling UART receiver: 8N1 frames, LSB first.
- Recovers bytes from the asynchronous serial line i_rxd using an internal oversample tick and 3-sample majority voting.
- Presents each byte through a valid/ready holding register, with frame-error and overrun flags.
- Sits beside the existing UART transmit path in the UART top level, driven from the same system clock; it does not use the shared baud divider.

Parameters:
- DIV, 4: system clocks per oversample tick (≥2).
- OVERSAMPLE, 16: ticks per bit period (even, ≥8).
- DATA_BITS, 8: data bits per frame.

Ports:
- i_clk, input, 1: system clock, rising edge.
- i_reset, input, 1: asynchronous, active-low reset.
- i_rxd, input, 1: serial line, asynchronous; idle level 1.
- i_ready, input, 1: consumer accepts o_data this cycle.
- o_data, output, DATA_BITS: received byte; valid while o_valid=1.
- o_valid, output, 1: o_data holds an unconsumed byte.
- o_frame_err, output, 1: one-cycle pulse when the stop bit is sampled as 0.
- o_overrun, output, 1: one-cycle pulse when a completed byte is dropped.
- o_busy, output, 1: state is not IDLE.

Behaviour:
- Reset (i_reset=0, asynchronous, any time including mid-frame):
  - state=IDLE; all counters = 0; shift register = 0.
  - Synchronizer flops = 1.
  - o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
- Input path: i_rxd passes through a 2-flop synchronizer; rxs denotes the second flop. All decisions use rxs only.
- Tick generator: counter 0..DIV-1; tick asserts for one cycle when the counter equals DIV-1. The counter is forced to 0 in IDLE, so the first tick comes DIV cycles after start detection.
- Sample counter: scnt counts ticks 0..OVERSAMPLE-1 within each bit and wraps to 0 at bit boundaries.
- Bit decision: majority of rxs captured at ticks scnt = M-1, M, M+1, where M = OVERSAMPLE/2. The decision is made at tick M+1.
- State IDLE:
  - Enter START when rxs=0; clear scnt, the bit index, and the tick counter.
- State START:
  - Voted 0 → continue to scnt=OVERSAMPLE-1, then enter DATA.
  - Voted 1 (glitch) → return to IDLE immediately; no flags raised.
- State DATA:
  - Each bit lasts OVERSAMPLE ticks; the voted bit shifts into the MSB of the shift register (LSB-first line order).
  - After DATA_BITS bits, enter STOP.
- State STOP, decision at tick M+1:
  - Voted 1 → deliver the byte (see holding register), then return to IDLE. This allows back-to-back frames whose start edge arrives in the second half of the stop bit.
  - Voted 0 → pulse o_frame_err for 1 cycle, discard the byte, enter BREAK.
- State BREAK: remain until rxs=1, then enter IDLE. No start detection occurs while rxs stays low.
- Holding register and handshake:
  - A transfer occurs on any cycle with o_valid=1 and i_ready=1; o_valid clears the next cycle unless a new byte is loaded that same cycle.
  - Delivery with o_valid=0, or with o_valid=1 and i_ready=1 in the same cycle: load o_data and set o_valid=1 on the next edge. Latency is 1 cycle after the stop decision tick.
  - Delivery with o_valid=1 and i_ready=0: keep the old o_data and o_valid; drop the new byte; pulse o_overrun for 1 cycle.
  - o_data is stable while o_valid=1 and i_ready=0.
- Bit period = DIV×OVERSAMPLE clocks (64 at defaults).
- Total frame = (2+DATA_BITS)×bit period; reception tolerates roughly ±4% baud mismatch at defaults.

Test Plan (defaults: 64 clocks per bit; bench drives i_rxd bit-accurately):
- Reset release, then frame 0xA5 with i_ready=0 → o_valid=1, o_data=0xA5, o_frame_err=0, o_busy=0 after stop. o_valid holds 500 cycles; raise i_ready for 1 cycle → o_valid=0 next cycle.
- Line-low glitch of 20 clocks, then idle → o_busy pulses, then returns to 0. No o_valid, o_frame_err, or o_overrun. A subsequent frame 0x3C is received correctly.
- Frame 0x3C with stop bit 0, line held low 300 clocks, then high → single o_frame_err pulse, o_valid stays 0, state remains BREAK until high. Next frame 0x55 → o_data=0x55.
- i_ready=0; frames 0x11 then 0x22 back-to-back → after the second stop, o_overrun pulses once, o_data stays 0x11, o_valid=1. Assert i_ready → 0x11 consumed; 0x22 never appears.
- i_ready tied 1; frames 0x00, 0xFF, 0x81 back-to-back (next start edge 40 clocks after stop-bit mid) → three single-cycle o_valid pulses with 0x00, 0xFF, 0x81, in order; no flags.
- i_reset low during bit 3 of frame 0xC3, released mid-frame → all outputs 0 immediately. Remaining bits produce no valid output (a frame error is acceptable only if the bench keeps bits low). A clean frame 0x7E afterwards → o_data=0x7E.
